// File: rtl/alu_wb_arb.sv
// Writeback arbiter for the dual integer ALU pipes.
// Each pipe's results go into a per-pipe FIFO. The FIFO heads share one CDB port, which uses a
// valid/ready handshake. Arbitration is round-robin between the two pipes.
// The issue stage is stalled early enough to absorb ALU results that are already in flight.
// Optional feature: define ALU_WB_BYPASS_EN to let a result reach the CDB in the same cycle
// when its FIFO is empty.
module alu_wb_arb #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STALL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid0_i,
    input  logic [63:0] result_0_i,
    input  logic [6:0]  dest_phys_0_i,
    input  logic [7:0]  rob_idx_0_i,
    input  logic        valid1_i,
    input  logic [63:0] result_1_i,
    input  logic [6:0]  dest_phys_1_i,
    input  logic [7:0]  rob_idx_1_i,
    input  logic        flush_i,
    output logic        cdb_valid_o,
    input  logic        cdb_ready_i,
    output logic [63:0] cdb_result_o,
    output logic [6:0]  cdb_dest_phys_o,
    output logic [7:0]  cdb_rob_idx_o,
    output logic        cdb_src_o,
    output logic        stall_o,
    output logic        overflow_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned DW       = 64 + 7 + 8;
    localparam logic [AW:0] CntFull  = (AW+1)'(DEPTH);
    localparam logic [AW:0] StallThr = (AW+1)'(DEPTH - STALL_MARGIN);

    // FIFO state, one set per pipe
    logic [DW-1:0] r_mem  [2][DEPTH];
    logic [AW-1:0] r_wptr [2];
    logic [AW-1:0] r_rptr [2];
    logic [AW:0]   r_cnt  [2];

    logic r_last;      // pipe granted at the last handshake
    logic r_lock;      // an offer was left pending last cycle; keep the same grant
    logic r_lock_src;
    logic r_stall;
    logic r_ovf;

    logic [DW-1:0] w_in_data   [2];
    logic [DW-1:0] w_head_data [2];
    logic [DW-1:0] w_cand_data [2];
    logic [AW:0]   w_cnt_nxt   [2];
    logic [1:0]    w_in_vld;
    logic [1:0]    w_head_vld;
    logic [1:0]    w_byp;
    logic [1:0]    w_cand;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [1:0]    w_drop;
    logic          w_grant;
    logic          w_out_vld;
    logic          w_hs;

    assign w_in_data[0] = {result_0_i, dest_phys_0_i, rob_idx_0_i};
    assign w_in_data[1] = {result_1_i, dest_phys_1_i, rob_idx_1_i};
    assign w_in_vld     = {valid1_i, valid0_i};

    // FIFO heads and the per-pipe arbitration candidates
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_head_vld[i]  = (r_cnt[i] != '0);
            w_head_data[i] = r_mem[i][r_rptr[i]];
`ifdef ALU_WB_BYPASS_EN
            // A result that a flush is about to discard is not offered.
            w_byp[i]       = ~w_head_vld[i] & w_in_vld[i] & ~flush_i;
`else
            w_byp[i]       = 1'b0;
`endif
            w_cand[i]      = w_head_vld[i] | w_byp[i];
            w_cand_data[i] = w_head_vld[i] ? w_head_data[i] : w_in_data[i];
        end
    end

    // Round-robin grant; held while an offer is pending so the payload stays stable
    always_comb begin
        w_grant = 1'b0;
        if (r_lock) begin
            w_grant = r_lock_src;
        end else if (w_cand[0] && w_cand[1]) begin
            w_grant = ~r_last;
        end else if (w_cand[1]) begin
            w_grant = 1'b1;
        end
    end

    assign w_out_vld = |w_cand;
    assign w_hs      = w_out_vld & cdb_ready_i & ~flush_i;

    // CDB outputs are zero whenever nothing is offered
    always_comb begin
        cdb_valid_o     = w_out_vld;
        cdb_src_o       = w_out_vld & w_grant;
        cdb_result_o    = '0;
        cdb_dest_phys_o = '0;
        cdb_rob_idx_o   = '0;
        if (w_out_vld) begin
            {cdb_result_o, cdb_dest_phys_o, cdb_rob_idx_o} = w_cand_data[w_grant];
        end
    end

    // Push/pop decisions and next counts
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic granted;
            logic push_req;
            logic full;
            granted   = w_hs & (w_grant == 1'(i));
            // A bypassed result that is accepted directly is not written into the FIFO.
            push_req  = w_in_vld[i] & ~flush_i & ~(granted & w_byp[i]);
            full      = (r_cnt[i] == CntFull);
            w_pop[i]  = granted & w_head_vld[i];
            w_push[i] = push_req & (~full | w_pop[i]);
            w_drop[i] = push_req & full & ~w_pop[i];
            if (flush_i) begin
                w_cnt_nxt[i] = '0;
            end else begin
                unique case ({w_push[i], w_pop[i]})
                    2'b10:   w_cnt_nxt[i] = r_cnt[i] + (AW+1)'(1);
                    2'b01:   w_cnt_nxt[i] = r_cnt[i] - (AW+1)'(1);
                    default: w_cnt_nxt[i] = r_cnt[i];
                endcase
            end
        end
    end

    // FIFO pointers and counts, arbitration state, stall and overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_last     <= 1'b1;  // pipe 0 wins the first tie
            r_lock     <= 1'b0;
            r_lock_src <= 1'b0;
            r_stall    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                if (flush_i) begin
                    r_wptr[i] <= '0;
                    r_rptr[i] <= '0;
                end else begin
                    if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
                    if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
                end
            end
            if (w_hs) r_last <= w_grant;
            r_lock     <= w_out_vld & ~cdb_ready_i & ~flush_i;
            r_lock_src <= w_grant;
            r_stall    <= (w_cnt_nxt[0] >= StallThr) | (w_cnt_nxt[1] >= StallThr);
            r_ovf      <= r_ovf | (|w_drop);
        end
    end

    // FIFO storage; no reset needed since the counts gate visibility
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) r_mem[i][r_wptr[i]] <= w_in_data[i];
        end
    end

    assign stall_o    = r_stall;
    assign overflow_o = r_ovf;

endmodule

// File: doc/alu_wb_arb.md
Name: alu_wb_arb

Overview:
- Writeback stage directly downstream of the dual integer ALU pipes.
- Accepts two registered ALU result streams; these carry valid, result, dest_phys and rob_idx, and have no backpressure.
- Buffers each stream in a per-pipe FIFO and merges them onto one result-bus (CDB) port with a valid/ready handshake.
- Round-robin arbitration between pipes. Raises an issue-stall early enough to cover ALU results already in flight.

Parameters:
DEPTH, 4, entries per pipe FIFO; power of two, minimum 4.
STALL_MARGIN, 2, free-entry margin for stall; covers 1 result in the ALU register plus 1 being issued.

Ports:
clk  in  1  clock
rst_n  in  1  reset
valid0_i  in  1  pipe-0 result valid
result_0_i  in  64  pipe-0 result
dest_phys_0_i  in  7  pipe-0 destination physical register
rob_idx_0_i  in  8  pipe-0 ROB index
valid1_i  in  1  pipe-1 result valid
result_1_i  in  64  pipe-1 result
dest_phys_1_i  in  7  pipe-1 destination physical register
rob_idx_1_i  in  8  pipe-1 ROB index
flush_i  in  1  pipeline flush; discard all buffered and incoming results
cdb_valid_o  out  1  result-bus entry valid
cdb_ready_i  in  1  result bus accepts entry
cdb_result_o  out  64  result-bus data
cdb_dest_phys_o  out  7  result-bus destination register
cdb_rob_idx_o  out  8  result-bus ROB index
cdb_src_o  out  1  granted pipe (0/1)
stall_o  out  1  issue must not send new ALU ops
overflow_o  out  1  sticky error: write attempted into full FIFO

Behaviour:
- Reset rst_n: asynchronous, active-low. Clock clk.
- Reset state:
  - FIFOs empty, RR pointer = pipe 0 preferred.
  - cdb_valid_o=0; cdb_result_o, cdb_dest_phys_o, cdb_rob_idx_o, cdb_src_o = 0.
  - stall_o=0, overflow_o=0.
  - Reset mid-operation discards all entries.
- Push: validN_i=1 writes {result, dest, rob} into FIFO N at the clock edge.
- Visibility: an entry written at edge N is visible at the FIFO head in the cycle after edge N. Minimum latency is 1 cycle.
- Arbitration: combinational over the two FIFO heads.
  - Only one head valid: grant it.
  - Both valid: grant the pipe opposite to the last successful grant.
  - RR pointer updates only on handshake (cdb_valid_o & cdb_ready_i).
- Result bus:
  - cdb_valid_o = any head valid. Payload and cdb_src_o come from the granted head.
  - Payload must hold stable while cdb_valid_o=1 and cdb_ready_i=0, unless flush_i is asserted.
- Pop: on handshake the granted FIFO pops; the other FIFO is untouched.
- Push and pop on the same FIFO in the same cycle: both occur, count unchanged.
  - Legal even when the FIFO is full, because the pop frees the slot.
- Overflow: push into a full FIFO without a simultaneous pop drops the push and sets overflow_o.
  - overflow_o stays set until reset.
- Stall: stall_o = (count0 >= DEPTH-STALL_MARGIN) | (count1 >= DEPTH-STALL_MARGIN).
  - Registered, so it reflects counts after the current edge.
- Flush: flush_i=1 at an edge empties both FIFOs.
  - Same-cycle validN_i pushes are dropped, and no handshake is counted.
  - cdb_valid_o=0 in the following cycle. RR pointer unchanged.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro ALU_WB_BYPASS_EN.
- Defined:
  - Applies when FIFO N is empty, validN_i=1, and pipe N would win arbitration.
  - The incoming result drives the result bus in the same cycle (0-cycle latency).
  - On handshake it is not written into the FIFO. Without handshake it is written normally.
  - Arbitration treats a bypass candidate as a valid head for that pipe.
- Undefined: no combinational input-to-output path; minimum latency 1 cycle.

Test Plan:
- Single result: valid0_i=1 with result 0x1234, dest 5, rob 9, cdb_ready_i=1 -> next cycle cdb_valid_o=1, payload 0x1234/5/9, src=0; following cycle cdb_valid_o=0.
- Simultaneous results: both pipes push every cycle for 4 cycles, cdb_ready_i=1 -> grants alternate 0,1,0,1,...; all 8 entries delivered with no loss; stall_o asserts once a count reaches 2.
- Backpressure: cdb_ready_i=0, pipe 0 pushes 4 entries -> stall_o=1 after 2nd push; FIFO full after 4th; payload stable. A 5th push -> overflow_o=1 and data dropped. Releasing ready drains the 4 entries in order.
- Flush: 3 entries buffered, flush_i=1 together with valid1_i=1 -> next cycle cdb_valid_o=0, stall_o=0; the later push is the only entry delivered.
- Reset mid-drain: assert rst_n=0 asynchronously while cdb_valid_o=1 -> all outputs 0 immediately; no stale entries after release.
- Bypass (macro defined): both FIFOs empty, valid1_i=1, ready=1 -> cdb_valid_o=1 in the same cycle, src=1, FIFO 1 stays empty.
